// File: rtl/cyclic_encoder_serial.sv
// Bit-serial systematic (N,K) cyclic encoder: K message bits pass straight through, then
// N-K parity bits are shifted out of an LFSR divider built from GEN_POLY; valid/ready both sides.
module cyclic_encoder_serial #(
  parameter int              N        = 7,
  parameter int              K        = 4,
  parameter logic [N-K:0]    GEN_POLY = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clr,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_first,
  output logic out_last,
  output logic busy
);

  localparam int P  = N - K;
  localparam int CW = $clog2(N);

  generate
    if (K < 1 || K >= N || GEN_POLY[0] != 1'b1 || GEN_POLY[P] != 1'b1) begin : g_bad_cfg
      $fatal(1, "cyclic_encoder_serial: invalid N/K/GEN_POLY");
    end
  endgenerate

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [P-1:0]  r_par;

  logic          w_live;
  logic          w_xfer;
  logic          w_fb;
  logic [P-1:0]  w_par_msg;

  // Outputs are combinational so message bits pass through with zero latency.
  assign w_live    = ~rst & ena & ~clr;
  assign in_ready  = w_live & (r_state == ST_MSG) & out_ready;
  assign out_valid = w_live & ((r_state == ST_PAR) | in_valid);
  assign out_bit   = (r_state == ST_MSG) ? in_bit : r_par[P-1];
  assign w_xfer    = out_valid & out_ready;
  assign out_first = out_valid & (r_cnt == '0);
  assign out_last  = out_valid & (r_cnt == CW'(N - 1));
  assign busy      = (r_cnt != '0);

  assign w_fb = in_bit ^ r_par[P-1];

  always_comb begin
    w_par_msg    = '0;
    w_par_msg[0] = w_fb;
    for (int i = 1; i < P; i++) begin
      w_par_msg[i] = r_par[i-1] ^ (w_fb & GEN_POLY[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_MSG;
      r_cnt   <= '0;
      r_par   <= '0;
    end else if (clr) begin
      r_state <= ST_MSG;
      r_cnt   <= '0;
      r_par   <= '0;
    end else if (w_xfer) begin
      if (r_state == ST_MSG) begin
        r_par <= w_par_msg;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == CW'(K - 1)) begin
          r_state <= ST_PAR;
        end
      end else if (r_cnt == CW'(N - 1)) begin
        r_state <= ST_MSG;
        r_cnt   <= '0;
        r_par   <= '0;
      end else begin
        r_par <= r_par << 1;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
